// File: rtl/key_mailbox_ctrl_if.sv
// Producer/consumer PicoBlaze port bundle for the key mailbox.
// master = the two cores (testbench side), slave = key_mailbox_ctrl.
interface key_mailbox_ctrl_if;
    logic [7:0] prod_port_id;
    logic [7:0] prod_out_port;
    logic       prod_write_strobe;
    logic       prod_read_strobe;
    logic [7:0] prod_in_port;
    logic [7:0] cons_port_id;
    logic [7:0] cons_out_port;
    logic       cons_write_strobe;
    logic       cons_read_strobe;
    logic [7:0] cons_in_port;
    logic       cons_interrupt;
    logic       cons_interrupt_ack;

    modport master (
        output prod_port_id, prod_out_port, prod_write_strobe, prod_read_strobe,
        output cons_port_id, cons_out_port, cons_write_strobe, cons_read_strobe,
        output cons_interrupt_ack,
        input  prod_in_port, cons_in_port, cons_interrupt
    );

    modport slave (
        input  prod_port_id, prod_out_port, prod_write_strobe, prod_read_strobe,
        input  cons_port_id, cons_out_port, cons_write_strobe, cons_read_strobe,
        input  cons_interrupt_ack,
        output prod_in_port, cons_in_port, cons_interrupt
    );
endinterface

// File: rtl/key_mailbox_ctrl.sv
// Key-byte FIFO + consumer interrupt sequencer between producer and cipher PicoBlaze cores.
// in_port reads have 1-cycle registered latency; no backpressure: a push into a full FIFO is dropped and flagged.
// Define KEYMBOX_DROP_CNT_EN to build the 8-bit saturating drop counter read on DROP_PORT.
module key_mailbox_ctrl #(
    parameter int         DEPTH         = 4,
    parameter int         IRQ_THRESHOLD = 1,
    parameter logic [7:0] KEY_PORT      = 8'h01,
    parameter logic [7:0] STATUS_PORT   = 8'h02,
    parameter logic [7:0] CTRL_PORT     = 8'h04,
    parameter logic [7:0] DROP_PORT     = 8'h08
) (
    input  logic              clk,
    input  logic              reset,
    key_mailbox_ctrl_if.slave mb
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(IRQ_THRESHOLD);

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_PEND, IRQ_SERVICE} irq_state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          ovf, unf, irq_en, irq_en_nxt;
    irq_state_t    irq_state;
    logic          push_req, pop_req, ctrl_wr, flush, clr;
    logic          empty, full, push_ok, pop_ok, drop;
    logic [7:0]    head, status, drop_rd;
    logic          unused_inputs;

    assign unused_inputs = ^{mb.prod_read_strobe, mb.cons_out_port[7:3]};

    always_comb begin
        push_req   = mb.prod_write_strobe && (mb.prod_port_id == KEY_PORT);
        pop_req    = mb.cons_read_strobe  && (mb.cons_port_id == KEY_PORT);
        ctrl_wr    = mb.cons_write_strobe && (mb.cons_port_id == CTRL_PORT);
        flush      = ctrl_wr && mb.cons_out_port[2];
        clr        = ctrl_wr && mb.cons_out_port[1];
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        pop_ok     = pop_req && !empty;
        // A pop frees the slot, so a full FIFO still accepts a same-cycle push
        push_ok    = push_req && (!full || pop_ok) && !flush;
        drop       = push_req && full && !pop_req;
        count_nxt  = count;
        if (flush)
            count_nxt = '0;
        else if (push_ok && !pop_ok)
            count_nxt = count + CW'(1);
        else if (!push_ok && pop_ok)
            count_nxt = count - CW'(1);
        irq_en_nxt = ctrl_wr ? mb.cons_out_port[0] : irq_en;
        head       = empty ? 8'h00 : mem[rd_ptr];
        status     = {4'(count), unf, ovf, full, empty};
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= mb.prod_out_port;
    end

`ifdef KEYMBOX_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            drop_cnt <= 8'h00;
        else if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'h01;
    end

    assign drop_rd = drop_cnt;
`else
    assign drop_rd = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            ovf               <= 1'b0;
            unf               <= 1'b0;
            irq_en            <= 1'b1;
            irq_state         <= IRQ_IDLE;
            mb.cons_interrupt <= 1'b0;
            mb.prod_in_port   <= 8'h00;
            mb.cons_in_port   <= 8'h00;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_nxt;
            ovf    <= clr ? 1'b0 : (ovf | drop);
            unf    <= clr ? 1'b0 : (unf | (pop_req && empty));
            irq_en <= irq_en_nxt;

            mb.prod_in_port <= (mb.prod_port_id == STATUS_PORT) ? status : 8'h00;
            if (mb.cons_port_id == KEY_PORT)
                mb.cons_in_port <= head;
            else if (mb.cons_port_id == STATUS_PORT)
                mb.cons_in_port <= status;
            else if (mb.cons_port_id == DROP_PORT)
                mb.cons_in_port <= drop_rd;
            else
                mb.cons_in_port <= 8'h00;

            // Decisions use post-update count/irq_en so the interrupt follows the push edge directly
            case (irq_state)
                IRQ_IDLE: begin
                    if (irq_en_nxt && (count_nxt >= THR_CNT)) begin
                        irq_state         <= IRQ_PEND;
                        mb.cons_interrupt <= 1'b1;
                    end
                end
                IRQ_PEND: begin
                    if (mb.cons_interrupt_ack) begin
                        irq_state         <= IRQ_SERVICE;
                        mb.cons_interrupt <= 1'b0;
                    end else if (!irq_en_nxt || flush) begin
                        irq_state         <= IRQ_IDLE;
                        mb.cons_interrupt <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (count_nxt == '0)
                        irq_state <= IRQ_IDLE;
                end
                default: begin
                    irq_state         <= IRQ_IDLE;
                    mb.cons_interrupt <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/key_mailbox_ctrl.md
Name: key_mailbox_ctrl

Overview:
Controller that carries one-time-pad key bytes from the random-generator PicoBlaze (producer) to the cipher PicoBlaze (consumer).
- Buffers key bytes in a small FIFO.
- Raises and sequences the consumer interrupt, and handles the interrupt_ack handshake.
- Presents key and status bytes on each core's in_port.
- It replaces the single-byte output latch and interrupt flip-flop between the two cores.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..8.
IRQ_THRESHOLD, 1, fill level (1..DEPTH) at which the consumer is interrupted.
KEY_PORT, 8'h01, port_id for key push (producer write) and key pop (consumer read).
STATUS_PORT, 8'h02, port_id for status read (both cores).
CTRL_PORT, 8'h04, port_id for consumer control write.
DROP_PORT, 8'h08, port_id for drop-counter read (consumer).

Ports:
clk  in  1  clock
reset  in  1  reset
prod_port_id  in  8  producer port_id
prod_out_port  in  8  producer write data
prod_write_strobe  in  1  producer write strobe
prod_read_strobe  in  1  producer read strobe (unused beyond decode)
prod_in_port  out  8  producer read data
cons_port_id  in  8  consumer port_id
cons_out_port  in  8  consumer write data
cons_write_strobe  in  1  consumer write strobe
cons_read_strobe  in  1  consumer read strobe
cons_in_port  out  8  consumer read data
cons_interrupt  out  1  interrupt to consumer
cons_interrupt_ack  in  1  consumer interrupt acknowledge

Behaviour:
Interface and reset:
- reset is synchronous, active-high; clock is clk.
- Port decode is an exact 8-bit match on port_id.
- Reset values: FIFO empty, count 0, ovf=0, unf=0, irq_en=1, IRQ FSM in IDLE, cons_interrupt=0, both in_ports 8'h00.
- Reset mid-operation discards FIFO contents and returns every output to its reset value on the next edge.

FIFO push:
- prod_write_strobe with prod_port_id==KEY_PORT pushes prod_out_port.
- Push when full: byte is dropped and ovf is set (sticky).

FIFO pop:
- cons_read_strobe with cons_port_id==KEY_PORT pops the head entry.
- The data returned is the head value presented on cons_in_port in that same cycle.
- Pop when empty: returns 8'h00, state is unchanged, and unf is set (sticky).

Simultaneous push and pop:
- Both take effect and count is unchanged.
- When full: both succeed and ovf is not set.
- When empty: the pop underflows (no bypass) and the push succeeds, giving count=1.

Read data:
- in_port is registered, updated every cycle from the current port_id decode, giving 1-cycle latency.
- This is valid because port_id is stable for 2 cycles before read_strobe samples.
- cons_in_port: KEY_PORT gives the head (8'h00 if empty); STATUS_PORT gives status; DROP_PORT gives the drop count; any other port gives 8'h00.
- prod_in_port: STATUS_PORT gives status; any other port gives 8'h00.
- Status byte: [0]=empty, [1]=full, [2]=ovf, [3]=unf, [7:4]=count.

Control (consumer write to CTRL_PORT):
- bit0 = irq_en, latched.
- bit1 = clear ovf, unf and the drop counter; self-clearing pulse.
- bit2 = flush FIFO; self-clearing pulse.
- A flush in the same cycle as a push: the flush wins and the byte is discarded.

Interrupt FSM (cons_interrupt is a registered output):
- IDLE: cons_interrupt=0. Go to PEND when irq_en and count >= IRQ_THRESHOLD.
- PEND: cons_interrupt=1.
  - cons_interrupt_ack: go to SERVICE.
  - irq_en cleared or FIFO flushed: go to IDLE.
- SERVICE: cons_interrupt=0. Go to IDLE only when count==0.
  - This gives no re-interrupt while the ISR drains; a new push during SERVICE does not retrigger.
- An ack in IDLE or SERVICE is ignored.
- Threshold evaluation uses the count after the current cycle's push/pop.
- cons_interrupt rises 1 cycle after the qualifying push edge.

Optional Feature:
Macro KEYMBOX_DROP_CNT_EN.
- Defined: an 8-bit saturating counter increments on each dropped push (overflow). It saturates at 8'hFF, is read on DROP_PORT, and is cleared by CTRL bit1 and by reset.
- Undefined: no counter logic is built and DROP_PORT reads 8'h00.

Test Plan:
1. Reset, then producer reads STATUS_PORT -> 8'h01; cons_interrupt=0.
2. Producer pushes 8'hA5 -> cons_interrupt=1 next cycle. Consumer acks -> interrupt=0. Consumer reads KEY_PORT -> 8'hA5. Status -> 8'h01; FSM returns to IDLE.
3. Push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with DEPTH=4 -> status 8'h46 (full, ovf, count 4). Pops return 11, 22, 33, 44. With KEYMBOX_DROP_CNT_EN, DROP_PORT reads 8'h01.
4. Pop on empty FIFO -> returns 8'h00, unf set. Write CTRL 8'h03 -> status 8'h01.
5. Fill to 4, then same-cycle push 8'h66 and pop -> pop returns the head, count stays 4, ovf=0. Simultaneous push/pop on empty -> count 1, unf=1.
6. In SERVICE with 2 entries, assert reset -> next cycle cons_interrupt=0 and status 8'h01. Push with irq_en=0 -> no interrupt. Then write CTRL 8'h01 -> interrupt asserts.
